// File: rtl/sram_tile_pkg.sv
// Shared constants, sequencer state type and helper functions for the tiled
// fakeram45_256x16 SRAM wrapper.
package sram_tile_pkg;

  localparam int TILE_ROWS = 256;
  localparam int TILE_W    = 16;

  typedef enum logic {
    IDLE   = 1'b0,
    RMW_WR = 1'b1
  } state_e;

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

  // Lane i of the byte enable covers bits [8i+7:8i]; callers truncate to width.
  function automatic logic [255:0] be_to_mask(input logic [31:0] be);
    logic [255:0] m;
    m = '0;
    for (int i = 0; i < 32; i++) begin
      m[i*8 +: 8] = {8{be[i]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/sram_rmw_tiled_if.sv
// Request/response bus of the tiled SRAM wrapper.
// Handshake: a request transfers on a cycle where Req_SI & Gnt_SO; Gnt_SO never
// depends on Req_SI. RValid_SO is a one-cycle pulse, there is no back-pressure.
interface sram_rmw_tiled_if #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 256
);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int BE_W   = (DATA_W + 7) / 8;

  logic              Req_SI;
  logic              Gnt_SO;
  logic              WrEn_SI;
  logic [BE_W-1:0]   BEn_SI;
  logic [ADDR_W-1:0] Addr_DI;
  logic [DATA_W-1:0] WrData_DI;
  logic              RValid_SO;
  logic [DATA_W-1:0] RdData_DO;
  logic              Busy_SO;

  modport master (
    output Req_SI, WrEn_SI, BEn_SI, Addr_DI, WrData_DI,
    input  Gnt_SO, RValid_SO, RdData_DO, Busy_SO
  );

  modport slave (
    input  Req_SI, WrEn_SI, BEn_SI, Addr_DI, WrData_DI,
    output Gnt_SO, RValid_SO, RdData_DO, Busy_SO
  );
endinterface

// File: rtl/fakeram45_256x16.sv
// Behavioural model of the 256x16 hard macro: active-low ce_in/we_in,
// active-high bit write mask, rd_out registered one cycle after a read.
module fakeram45_256x16 (
  input  logic        clk,
  input  logic        ce_in,
  input  logic        we_in,
  input  logic [7:0]  addr_in,
  input  logic [15:0] wd_in,
  input  logic [15:0] w_mask_in,
  output logic [15:0] rd_out
);
  logic [15:0] r_mem [256];

  always_ff @(posedge clk) begin
    if (!ce_in) begin
      if (!we_in) begin
        r_mem[addr_in] <= (r_mem[addr_in] & ~w_mask_in) | (wd_in & w_mask_in);
      end else begin
        rd_out <= r_mem[addr_in];
      end
    end
  end
endmodule

// File: rtl/sram_tile_row.sv
// One 256-row bank: NT macros side by side sharing ce/we/row, NT*16-bit data.
module sram_tile_row
  import sram_tile_pkg::*;
#(
  parameter int NT = 4
) (
  input  logic               i_clk,
  input  logic               i_ce_n,
  input  logic               i_we_n,
  input  logic [7:0]         i_row,
  input  logic [NT*TILE_W-1:0] i_wd,
  output logic [NT*TILE_W-1:0] o_rd
);
  for (genvar t = 0; t < NT; t++) begin : g_tile
    fakeram45_256x16 u_macro (
      .clk       (i_clk),
      .ce_in     (i_ce_n),
      .we_in     (i_we_n),
      .addr_in   (i_row),
      .wd_in     (i_wd[t*TILE_W +: TILE_W]),
      .w_mask_in ({TILE_W{1'b1}}),
      .rd_out    (o_rd[t*TILE_W +: TILE_W])
    );
  end
endmodule

// File: rtl/sram_rmw_tiled.sv
// Single-port SRAM wrapper tiling fakeram45_256x16 macros in width and depth;
// partial byte-enable writes are done as an internal read-modify-write.
module sram_rmw_tiled
  import sram_tile_pkg::*;
#(
  parameter int  DATA_W = 64,
  parameter int  DEPTH  = 256,
  localparam int ADDR_W = $clog2(DEPTH),
  localparam int BE_W   = ceil_div(DATA_W, 8),
  localparam int NT     = ceil_div(DATA_W, TILE_W),
  localparam int NB     = DEPTH / TILE_ROWS,
  localparam int BSEL_W = (NB > 1) ? (ADDR_W - 8) : 1
) (
  input  logic            Clk_CI,
  input  logic            Rst_RI,
  sram_rmw_tiled_if.slave bus,
  output state_e          o_dbg_state,
  output logic [NB-1:0]   o_dbg_ce_n
);
  localparam int PAD_W = NT * TILE_W;

  state_e            r_state, w_next;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;
  logic [BE_W-1:0]   r_ben;
  logic              r_rd_pend;
  logic [BSEL_W-1:0] r_rd_bank;
  logic [DATA_W-1:0] r_rd_hold;

  logic              w_accept, w_full, w_empty, w_latch, w_rd_issue, w_we_n;
  logic [NB-1:0]     w_ce_n;
  logic [7:0]        w_row;
  logic [PAD_W-1:0]  w_wd;
  logic [PAD_W-1:0]  w_rd_bank [NB];
  logic [BSEL_W-1:0] w_req_bank, w_rmw_bank;
  logic [DATA_W-1:0] w_mask, w_rmw_old, w_merged, w_rd_sel;

  function automatic logic [BSEL_W-1:0] bank_of(input logic [ADDR_W-1:0] a);
    return BSEL_W'(a >> 8);
  endfunction

  assign bus.Gnt_SO = (r_state == IDLE) & ~Rst_RI;
  assign w_accept   = bus.Req_SI & bus.Gnt_SO;
  assign w_full     = &bus.BEn_SI;
  assign w_empty    = ~|bus.BEn_SI;
  assign w_req_bank = bank_of(bus.Addr_DI);
  assign w_rmw_bank = bank_of(r_addr);

  // Enabled lanes take the latched write data, the rest keep what the macro read.
  assign w_mask    = DATA_W'(be_to_mask(32'(r_ben)));
  assign w_rmw_old = DATA_W'(w_rd_bank[w_rmw_bank]);
  assign w_merged  = (r_data & w_mask) | (w_rmw_old & ~w_mask);
  assign w_rd_sel  = DATA_W'(w_rd_bank[r_rd_bank]);

  always_comb begin
    w_next     = r_state;
    w_ce_n     = '1;
    w_we_n     = 1'b1;
    w_row      = bus.Addr_DI[7:0];
    w_wd       = PAD_W'(bus.WrData_DI);
    w_latch    = 1'b0;
    w_rd_issue = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (!bus.WrEn_SI) begin
            w_ce_n     = ~(NB'(1) << w_req_bank);
            w_rd_issue = 1'b1;
          end else if (w_full) begin
            w_ce_n = ~(NB'(1) << w_req_bank);
            w_we_n = 1'b0;
          end else if (!w_empty) begin
            w_ce_n  = ~(NB'(1) << w_req_bank);
            w_latch = 1'b1;
            w_next  = RMW_WR;
          end
        end
      end
      RMW_WR: begin
        w_ce_n = ~(NB'(1) << w_rmw_bank);
        w_we_n = 1'b0;
        w_row  = r_addr[7:0];
        w_wd   = PAD_W'(w_merged);
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
    // Reset gates every macro so an in-flight RMW write is dropped.
    if (Rst_RI) begin
      w_ce_n = '1;
      w_we_n = 1'b1;
      w_next = IDLE;
    end
  end

  always_ff @(posedge Clk_CI) begin
    if (Rst_RI) begin
      r_state   <= IDLE;
      r_rd_pend <= 1'b0;
      r_rd_bank <= '0;
      r_rd_hold <= '0;
      r_addr    <= '0;
      r_data    <= '0;
      r_ben     <= '0;
    end else begin
      r_state   <= w_next;
      r_rd_pend <= w_rd_issue;
      if (w_rd_issue) r_rd_bank <= w_req_bank;
      if (r_rd_pend)  r_rd_hold <= w_rd_sel;
      if (w_latch) begin
        r_addr <= bus.Addr_DI;
        r_data <= bus.WrData_DI;
        r_ben  <= bus.BEn_SI;
      end
    end
  end

  // rd_out is only valid in the cycle after the read, so the response is
  // presented straight from the macro then and held in r_rd_hold afterwards.
  assign bus.RValid_SO = r_rd_pend & ~Rst_RI;
  assign bus.RdData_DO = bus.RValid_SO ? w_rd_sel : r_rd_hold;
  assign bus.Busy_SO   = (r_state != IDLE);
  assign o_dbg_state   = r_state;
  assign o_dbg_ce_n    = w_ce_n;

  for (genvar b = 0; b < NB; b++) begin : g_bank
    sram_tile_row #(.NT(NT)) u_row (
      .i_clk  (Clk_CI),
      .i_ce_n (w_ce_n[b]),
      .i_we_n (w_we_n),
      .i_row  (w_row),
      .i_wd   (w_wd),
      .o_rd   (w_rd_bank[b])
    );
  end
endmodule
